// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 12-bit words over a simple req/ack memory port,
// presents decoded fields with a valid/ready handshake, and handles jumps and HALT.
module instr_fetch_unit #(
  parameter int IW   = 12,
  parameter int CNTW = 8
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [3:0]      imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic            instr_valid,
  input  logic            dec_ready,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs_imm,
  output logic [3:0]      instr_pc,
  input  logic            jmp_sel,
  input  logic [3:0]      jmp_target,
  output logic            halted,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALT
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t          state, state_nx;
  logic [3:0]      pc, pc_nx;
  logic [IW-1:0]   ir;
  logic [3:0]      ipc;
  logic            load;
  logic            accept;

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    load        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load     = 1'b1;
          state_nx = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (dec_ready) begin
          accept   = 1'b1;
          state_nx = (ir[11:8] == OP_HALT) ? HALT : FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  // PC advances when a word is captured; a taken jump replaces it at acceptance.
  always_comb begin
    pc_nx = pc;
    if (load)
      pc_nx = pc + 4'd1;
    else if (accept && jmp_sel)
      pc_nx = jmp_target;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      ipc     <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (load) begin
        ir  <= imem_data;
        ipc <= pc;
      end
      if (accept && (retired != '1))
        retired <= retired + CNTW'(1);
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir[11:8];
  assign rd        = ir[7:4];
  assign rs_imm    = ir[3:0];
  assign instr_pc  = ipc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a directed vector table for reset and
// the first instructions, then hand-written sequences for waits, stalls, jumps, wrap and halt.
module tb_instr_fetch_unit;

  localparam int IW   = 12;
  localparam int CNTW = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req;
  logic [3:0]      imem_addr;
  logic            imem_ack = 1'b0;
  logic [IW-1:0]   imem_data = '0;
  logic            instr_valid;
  logic            dec_ready = 1'b0;
  logic [3:0]      opcode, rd, rs_imm, instr_pc;
  logic            jmp_sel = 1'b0;
  logic [3:0]      jmp_target = '0;
  logic            halted;
  logic [CNTW-1:0] retired;

  instr_fetch_unit #(.IW(IW), .CNTW(CNTW)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .opcode      (opcode),
    .rd          (rd),
    .rs_imm      (rs_imm),
    .instr_pc    (instr_pc),
    .jmp_sel     (jmp_sel),
    .jmp_target  (jmp_target),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [11:0] data;
    logic        rdy;
    logic        js;
    logic [3:0]  jt;
    logic        e_req;
    logic [3:0]  e_addr;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [3:0]  e_rd;
    logic [3:0]  e_rs;
    logic [3:0]  e_ipc;
    logic [7:0]  e_ret;
    logic        e_halt;
  } vec_t;

  vec_t tbl [6];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  exp_pc;
  int unsigned exp_ret;
  int          acc_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] data_for(input logic [3:0] a);
    logic [3:0] op;
    op = (a == 4'hF) ? 4'hE : a;
    return {op, a + 4'd1, a + 4'd2};
  endfunction

  // One full instruction from FETCH: zero-wait ack, then accept with the given jump.
  task automatic run_instr(input logic [11:0] data, input logic js, input logic [3:0] jt);
    imem_ack = 1'b1; imem_data = data; dec_ready = 1'b0; jmp_sel = 1'b0;
    check("fetch_req",   imem_req,    1);
    check("fetch_addr",  imem_addr,   exp_pc);
    check("fetch_valid", instr_valid, 0);
    cyc();
    imem_ack = 1'b0; dec_ready = 1'b1; jmp_sel = js; jmp_target = jt;
    check("pres_valid",  instr_valid, 1);
    check("pres_req",    imem_req,    0);
    check("pres_opcode", opcode,      data[11:8]);
    check("pres_rd",     rd,          data[7:4]);
    check("pres_rs",     rs_imm,      data[3:0]);
    check("pres_ipc",    instr_pc,    exp_pc);
    check("pres_ret",    retired,     exp_ret);
    cyc();
    jmp_sel = 1'b0; dec_ready = 1'b0;
    exp_pc  = js ? jt : exp_pc + 4'd1;
    exp_ret = (exp_ret == 255) ? 255 : exp_ret + 1;
    acc_count++;
  endtask

  initial begin
    //          rst ack data     rdy js jt    req addr val op  rd  rs  ipc  ret  halt
    tbl[0] = '{1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 12'hFFF, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 12'h012, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b1, 4'h0, 4'h1, 4'h2, 4'h0, 8'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 4'h0, 4'h1, 4'h2, 4'h0, 8'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 4'h0, 1'b0, 4'h2, 1'b1, 4'h1, 4'h2, 4'h3, 4'h1, 8'd1, 1'b0};

    reset = 1'b1;
    cyc();
    cyc();

    for (int i = 0; i < 6; i++) begin
      reset = tbl[i].rst; imem_ack = tbl[i].ack; imem_data = tbl[i].data;
      dec_ready = tbl[i].rdy; jmp_sel = tbl[i].js; jmp_target = tbl[i].jt;
      check($sformatf("v%0d_req", i),    imem_req,    tbl[i].e_req);
      check($sformatf("v%0d_addr", i),   imem_addr,   tbl[i].e_addr);
      check($sformatf("v%0d_valid", i),  instr_valid, tbl[i].e_valid);
      check($sformatf("v%0d_opcode", i), opcode,      tbl[i].e_op);
      check($sformatf("v%0d_rd", i),     rd,          tbl[i].e_rd);
      check($sformatf("v%0d_rs", i),     rs_imm,      tbl[i].e_rs);
      check($sformatf("v%0d_ipc", i),    instr_pc,    tbl[i].e_ipc);
      check($sformatf("v%0d_ret", i),    retired,     tbl[i].e_ret);
      check($sformatf("v%0d_halt", i),   halted,      tbl[i].e_halt);
      cyc();
    end
    imem_ack = 1'b0; dec_ready = 1'b0; jmp_sel = 1'b0;
    exp_pc = 4'd2; exp_ret = 2; acc_count = 2;

    // Three wait cycles at address 2 with a stray jump pulse during FETCH.
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b0; jmp_sel = 1'b1; jmp_target = 4'h7; dec_ready = 1'b1;
      check("wait_req",   imem_req,    1);
      check("wait_addr",  imem_addr,   2);
      check("wait_valid", instr_valid, 0);
      check("wait_ret",   retired,     2);
      cyc();
    end
    run_instr(12'h234, 1'b0, 4'h0);

    // Stall at the instruction from address 3.
    imem_ack = 1'b1; imem_data = 12'h345;
    check("stall_fetch_addr", imem_addr, 3);
    cyc();
    for (int i = 0; i < 5; i++) begin
      dec_ready = 1'b0; imem_ack = 1'b1; imem_data = 12'hFFF; jmp_sel = 1'b1; jmp_target = 4'hC;
      check("stall_valid",  instr_valid, 1);
      check("stall_opcode", opcode,      4'h3);
      check("stall_rd",     rd,          4'h4);
      check("stall_rs",     rs_imm,      4'h5);
      check("stall_ipc",    instr_pc,    4'h3);
      check("stall_req",    imem_req,    0);
      check("stall_addr",   imem_addr,   4);
      check("stall_ret",    retired,     3);
      cyc();
    end
    dec_ready = 1'b1; imem_ack = 1'b0; jmp_sel = 1'b0;
    check("stall_release_valid", instr_valid, 1);
    cyc();
    dec_ready = 1'b0;
    check("stall_after_valid", instr_valid, 0);
    check("stall_after_req",   imem_req,    1);
    check("stall_after_addr",  imem_addr,   4);
    check("stall_after_ret",   retired,     4);
    exp_pc = 4'd4; exp_ret = 4; acc_count = 4;

    // Taken jump from address 4 to 9.
    run_instr(12'h456, 1'b1, 4'h9);
    check("jump_addr", imem_addr, 9);
    run_instr(data_for(exp_pc), 1'b0, 4'h0);

    // Straight-line through address 15 wraps to 0.
    for (int k = 0; k < 6; k++)
      run_instr(data_for(exp_pc), 1'b0, 4'h0);
    check("wrap_addr", imem_addr, 0);

    // Run on to 300 acceptances; the counter saturates.
    while (acc_count < 300)
      run_instr(data_for(exp_pc), 1'b0, 4'h0);
    check("sat_ret", retired, 8'hFF);

    run_instr(12'hF00, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; dec_ready = 1'b1;
      check("halt_halted", halted,      1);
      check("halt_req",    imem_req,    0);
      check("halt_valid",  instr_valid, 0);
      check("halt_ret",    retired,     8'hFF);
      cyc();
    end
    imem_ack = 1'b0; dec_ready = 1'b0;

    // Reset out of HALT, then reset in the middle of a FETCH with ack present.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_halted", halted,      0);
    check("rst_ret",    retired,     0);
    check("rst_req",    imem_req,    0);
    check("rst_valid",  instr_valid, 0);
    check("rst_addr",   imem_addr,   0);
    check("rst_ipc",    instr_pc,    0);
    check("rst_opcode", opcode,      0);
    cyc();
    exp_pc = 4'd0; exp_ret = 0;
    run_instr(data_for(4'd0), 1'b0, 4'h0);
    check("mid_req", imem_req, 1);
    reset = 1'b1; imem_ack = 1'b1; imem_data = 12'h777;
    cyc();
    reset = 1'b0; imem_ack = 1'b0;
    check("mid_rst_req",    imem_req,    0);
    check("mid_rst_valid",  instr_valid, 0);
    check("mid_rst_addr",   imem_addr,   0);
    check("mid_rst_ret",    retired,     0);
    check("mid_rst_opcode", opcode,      0);
    cyc();
    exp_pc = 4'd0; exp_ret = 0;
    run_instr(12'hF00, 1'b0, 4'h0);
    check("halt2_halted", halted,   1);
    check("halt2_ret",    retired,  1);
    check("halt2_req",    imem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
